muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
//  Iterative signed MULT/DIV engine with its own sequencer, owning the HI/LO register pair.
//  The multicycle control unit pulses start with an opcode, then stalls on busy until done.
//  One shared W-bit adder/subtractor is reused every cycle: shift-add for MULT, restoring for DIV.
//  HI/LO are read by MFHI/MFLO via hi_out/lo_out.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO width; iteration count
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  start        in   1      request; sampled only in IDLE
//  op           in   1      0=MULT, 1=DIV (signed, two's complement)
//  a            in   WIDTH  rs operand (multiplicand / dividend)
//  b            in   WIDTH  rt operand (multiplier / divisor)
//  busy         out  1      high whenever state != IDLE
//  done         out  1      one-cycle pulse: HI/LO valid (or div-by-zero flagged)
//  div_zero     out  1      one-cycle pulse with done when DIV and b==0
//  hi_out       out  WIDTH  HI register
//  lo_out       out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, counter=0.
//  - Reset mid-operation aborts; no done is issued.
//  States:
//  - IDLE: on start, latch |a|, |b|, sign_a, sign_b, op; counter=0.
//    Go to MUL, or DIV if b!=0; go to FINISH with dz flag if DIV and b==0.
//  - MUL: each edge, if mplier[0] then upper+=mcand; shift {carry,upper,mplier} right 1; counter++.
//    After WIDTH iterations (counter==WIDTH-1), go to FINISH.
//  - DIV: each edge, shift {rem,quot} left 1; trial=rem-|b|; if trial>=0 then rem=trial, quot[0]=1.
//    After WIDTH iterations, go to FINISH.
//  - FINISH: one edge. Apply signs, load HI/LO, done=1, then IDLE.
//    MULT: {HI,LO} = sign_a^sign_b ? -prod : prod (2W-bit negate).
//    DIV: LO = quot, negated if sign_a^sign_b; HI = rem, negated if sign_a (truncating, MIPS semantics).
//    Div-by-zero: HI/LO unchanged; div_zero=1 with done.
//  Latency, start sampled at edge k:
//  - busy=1 from edge k.
//  - done=1, busy=0 after edge k+WIDTH+1 (33 for WIDTH=32).
//  - Div-by-zero: done after edge k+1.
//  done, div_zero: registered, high exactly one cycle; cleared on every other edge.
//  Start handling:
//  - start while busy (incl. FINISH): ignored; not queued.
//  - start in the cycle done is high (state already IDLE): accepted (back-to-back).
//  Operands: a/b/op may change after the start edge without effect.
//  Overflow wrap:
//  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
//  - 0x80000000 * 0x80000000 gives HI=0x40000000, LO=0.
//  HI/LO change only on the FINISH edge (non-dz) or on reset.
// TESTING
//  1. MULT a=7, b=-3 -> done 33 edges after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high 33 cycles.
//  2. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7 / -2 -> LO=0xFFFFFFFD, HI=0x00000001.
//  3. After test 2, DIV a=5, b=0 -> done+div_zero after edge k+1; HI/LO keep 0x00000001/0xFFFFFFFD.
//  4. MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  5. Second start at iteration 5 with different a/b -> ignored, result of first op.
//     Reset at iteration 10 -> busy=0, HI=LO=0 next cycle; no done pulse.
//  6. Back-to-back: start asserted on done cycle (MULT 3*4 then DIV 12/4).
//     -> HI:LO=0:12, then LO=3, HI=0; each done a single-cycle pulse.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative signed MULT/DIV sequencer owning the HI/LO pair
// One shared (WIDTH+1)-bit adder does shift-add for MULT and restoring subtract for DIV.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;
    state_t state, state_nxt;

    // opnd: |a| for MULT, |b| for DIV. acc: upper product half / remainder.
    // lo_r: multiplier shifting out / quotient shifting in.
    logic [WIDTH-1:0] opnd, acc, lo_r, hi_q, lo_q;
    logic [CW-1:0]    counter;
    logic             sign_a, sign_b, op_r, dz_r, done_q, dz_q;
    logic             last_iter;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   add_x, add_y, add_sum;
    logic             add_cin;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign abs_a     = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
    assign abs_b     = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
    assign last_iter = (counter == CW'(WIDTH - 1));
    assign prod      = {acc, lo_r};
    assign prod_neg  = (2*WIDTH)'(0) - prod;

    always_comb begin
        add_x   = {1'b0, acc};
        add_y   = '0;
        add_cin = 1'b0;
        if (state == S_DIV) begin
            // trial = ({rem,quot} << 1).rem - |b|, as add of the complement
            add_x   = {acc, lo_r[WIDTH-1]};
            add_y   = ~{1'b0, opnd};
            add_cin = 1'b1;
        end else if (lo_r[0]) begin
            add_y = {1'b0, opnd};
        end
        add_sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op && (b == '0)) state_nxt = S_FINISH;
                    else if (op)         state_nxt = S_DIV;
                    else                 state_nxt = S_MUL;
                end
            end
            S_MUL:    if (last_iter) state_nxt = S_FINISH;
            S_DIV:    if (last_iter) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opnd    <= '0;
            acc     <= '0;
            lo_r    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            counter <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            op_r    <= 1'b0;
            dz_r    <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sign_a  <= a[WIDTH-1];
                        sign_b  <= b[WIDTH-1];
                        op_r    <= op;
                        dz_r    <= op && (b == '0);
                        counter <= '0;
                        acc     <= '0;
                        opnd    <= op ? abs_b : abs_a;
                        lo_r    <= op ? abs_a : abs_b;
                    end
                end
                S_MUL: begin
                    acc     <= add_sum[WIDTH:1];
                    lo_r    <= {add_sum[0], lo_r[WIDTH-1:1]};
                    counter <= counter + CW'(1);
                end
                S_DIV: begin
                    if (!add_sum[WIDTH]) acc <= add_sum[WIDTH-1:0];
                    else                 acc <= {acc[WIDTH-2:0], lo_r[WIDTH-1]};
                    lo_r    <= {lo_r[WIDTH-2:0], ~add_sum[WIDTH]};
                    counter <= counter + CW'(1);
                end
                S_FINISH: begin
                    done_q <= 1'b1;
                    dz_q   <= dz_r;
                    if (!dz_r) begin
                        if (!op_r) begin
                            {hi_q, lo_q} <= (sign_a ^ sign_b) ? prod_neg : prod;
                        end else begin
                            // truncating division: remainder takes the dividend's sign
                            lo_q <= (sign_a ^ sign_b) ? (WIDTH'(0) - lo_r) : lo_r;
                            hi_q <= sign_a ? (WIDTH'(0) - acc) : acc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
endmodule
